// File: rtl/vermibus_arbiter_pkg.sv
// Shared Vermibus types and the arbiter state encoding.
package vermibus_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/vermibus_arbiter_if.sv
// Requester-side and target-side Vermibus signals of the arbiter.
// 'master' is the arbiter's view; 'slave' is the view of the surrounding requesters/target.
interface vermibus_arbiter_if #(
  parameter int N_CHANNELS = 2
);
  import vermibus_arbiter_pkg::*;

  logic     [N_CHANNELS-1:0] m_valid;
  word_t    [N_CHANNELS-1:0] m_address;
  wstrobe_t [N_CHANNELS-1:0] m_wstrobe;
  word_t    [N_CHANNELS-1:0] m_wdata;
  logic     [N_CHANNELS-1:0] m_ready;
  word_t    [N_CHANNELS-1:0] m_rdata;
  logic     [N_CHANNELS-1:0] m_irq;

  logic     s_valid;
  word_t    s_address;
  wstrobe_t s_wstrobe;
  word_t    s_wdata;
  logic     s_ready;
  word_t    s_rdata;
  logic     s_irq;

  modport master (
    input  m_valid, m_address, m_wstrobe, m_wdata, s_ready, s_rdata, s_irq,
    output m_ready, m_rdata, m_irq, s_valid, s_address, s_wstrobe, s_wdata
  );

  modport slave (
    output m_valid, m_address, m_wstrobe, m_wdata, s_ready, s_rdata, s_irq,
    input  m_ready, m_rdata, m_irq, s_valid, s_address, s_wstrobe, s_wdata
  );

endinterface

// File: rtl/vermibus_rr_picker.sv
// Combinational picker: first set request scanning from start_i upward, modulo N.
// Fixed priority is obtained by tying start_i to zero.
module vermibus_rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  always_comb begin
    int unsigned j;
    j       = 0;
    idx_o   = '0;
    found_o = 1'b0;
    // Scan from the farthest offset down so the closest request to start_i is written last.
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(start_i) + i) % N;
      if (req_i[$clog2(N)'(j)]) begin
        idx_o   = $clog2(N)'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vermibus_arbiter.sv
// Merges N_CHANNELS Vermibus requesters onto one target; grant held for a whole transaction.
// One cycle of arbitration latency in IDLE; optional watchdog forces an error completion.
module vermibus_arbiter
  import vermibus_arbiter_pkg::*;
#(
  parameter int    N_CHANNELS     = 2,
  parameter int    ROUND_ROBIN    = 1,
  parameter int    TIMEOUT_CYCLES = 0,
  parameter word_t ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               reset_n,
  vermibus_arbiter_if.master bus,
  output logic               timeout
);

  localparam int GW = $clog2(N_CHANNELS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [GW-1:0] pick_start;
  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic [GW-1:0] grant_inc;
  logic          req_vld;
  logic          wd_hit;

  assign pick_start = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

  vermibus_rr_picker #(
    .N (N_CHANNELS)
  ) u_picker (
    .req_i   (bus.m_valid),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign grant_inc = (grant_q == GW'(N_CHANNELS - 1)) ? '0 : grant_q + GW'(1);
  assign req_vld   = bus.m_valid[grant_q];
  assign wd_hit    = (TIMEOUT_CYCLES > 0) && (cnt_q == WD_LAST);

  // Interrupt is a pure wire, unaffected by state or reset.
  assign bus.m_irq = {N_CHANNELS{bus.s_irq}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    bus.s_valid   = 1'b0;
    bus.s_address = '0;
    bus.s_wstrobe = '0;
    bus.s_wdata   = '0;
    bus.m_ready   = '0;
    bus.m_rdata   = '0;
    timeout       = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end

      ARB_BUSY: begin
        bus.s_address          = bus.m_address[grant_q];
        bus.s_wstrobe          = bus.m_wstrobe[grant_q];
        bus.s_wdata            = bus.m_wdata[grant_q];
        bus.m_rdata[grant_q]   = bus.s_rdata;
        if (!req_vld) begin
          // Requester withdrew mid-transaction: drop it without a completion.
          state_d = ARB_IDLE;
        end else if (bus.s_ready) begin
          bus.s_valid          = 1'b1;
          bus.m_ready[grant_q] = 1'b1;
          state_d              = ARB_IDLE;
          rr_ptr_d             = grant_inc;
        end else if (wd_hit) begin
          bus.m_ready[grant_q] = 1'b1;
          bus.m_rdata[grant_q] = ERROR_DATA;
          timeout              = 1'b1;
          state_d              = ARB_IDLE;
          rr_ptr_d             = grant_inc;
        end else begin
          bus.s_valid = 1'b1;
          cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Directed bench: cycle table on a round-robin/watchdog instance, hand sequences for reset and fixed priority.
module tb_vermibus_arbiter;
  import vermibus_arbiter_pkg::*;

  localparam word_t    A0   = 32'h0000_0100;
  localparam word_t    A1   = 32'h0000_A102;
  localparam wstrobe_t WS1  = 4'b1100;
  localparam word_t    WD1  = 32'h0096_0096;
  localparam word_t    EDAT = 32'hDEAD_BEEF;

  logic clk;
  logic reset_n;
  logic to_rr;
  logic to_fp;

  int n_tests = 0;
  int n_fail  = 0;

  vermibus_arbiter_if #(.N_CHANNELS(2)) bus_rr ();
  vermibus_arbiter_if #(.N_CHANNELS(2)) bus_fp ();

  vermibus_arbiter #(
    .N_CHANNELS     (2),
    .ROUND_ROBIN    (1),
    .TIMEOUT_CYCLES (4),
    .ERROR_DATA     (32'hDEADBEEF)
  ) dut_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_rr),
    .timeout (to_rr)
  );

  vermibus_arbiter #(
    .N_CHANNELS     (2),
    .ROUND_ROBIN    (0),
    .TIMEOUT_CYCLES (0),
    .ERROR_DATA     (32'hDEADBEEF)
  ) dut_fp (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_fp),
    .timeout (to_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mv;
    logic       sr;
    word_t      rd;
    logic       irq;
    logic       sv;
    word_t      sa;
    wstrobe_t   sw;
    word_t      swd;
    logic [1:0] mr;
    word_t      r0;
    word_t      r1;
    logic       to;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [1:0] mv, input logic sr, input word_t rd, input logic irq,
                              input logic sv, input int ch, input logic [1:0] mr,
                              input word_t r0, input word_t r1, input logic to);
    vec_t v;
    v.mv = mv; v.sr = sr; v.rd = rd; v.irq = irq;
    v.sv = sv; v.mr = mr; v.r0 = r0; v.r1 = r1; v.to = to;
    // ch selects which channel's request fields should appear on s_*: -1 means all zero.
    v.sa  = (ch == 0) ? A0 : (ch == 1) ? A1 : 32'h0;
    v.sw  = (ch == 1) ? WS1 : 4'h0;
    v.swd = (ch == 1) ? WD1 : 32'h0;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_rr(input logic [1:0] mv, input logic sr, input word_t rd, input logic irq);
    bus_rr.m_valid = mv;
    bus_rr.s_ready = sr;
    bus_rr.s_rdata = rd;
    bus_rr.s_irq   = irq;
  endtask

  initial begin
    // Idle-state vectors use s_rdata=0 so m_rdata expectations do not depend on idle forwarding.
    tbl[0]  = mk(2'b01, 0, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[1]  = mk(2'b01, 1, 32'h1111_1111, 1, 1,  0, 2'b01, 32'h1111_1111, 32'h0,        0);
    tbl[2]  = mk(2'b00, 0, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[3]  = mk(2'b10, 0, 32'h0,        1, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[4]  = mk(2'b10, 0, 32'h0,        0, 1,  1, 2'b00, 32'h0,        32'h0,        0);
    tbl[5]  = mk(2'b10, 1, 32'h2222_2222, 0, 1,  1, 2'b10, 32'h0,        32'h2222_2222, 0);
    tbl[6]  = mk(2'b11, 1, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[7]  = mk(2'b11, 1, 32'h3333_3333, 0, 1,  0, 2'b01, 32'h3333_3333, 32'h0,        0);
    tbl[8]  = mk(2'b11, 1, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[9]  = mk(2'b11, 1, 32'h4444_4444, 0, 1,  1, 2'b10, 32'h0,        32'h4444_4444, 0);
    tbl[10] = mk(2'b11, 1, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[11] = mk(2'b11, 1, 32'h5555_5555, 0, 1,  0, 2'b01, 32'h5555_5555, 32'h0,        0);
    tbl[12] = mk(2'b11, 0, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[13] = mk(2'b11, 0, 32'h0,        0, 1,  1, 2'b00, 32'h0,        32'h0,        0);
    tbl[14] = mk(2'b11, 0, 32'h0,        0, 1,  1, 2'b00, 32'h0,        32'h0,        0);
    tbl[15] = mk(2'b11, 0, 32'h0,        0, 1,  1, 2'b00, 32'h0,        32'h0,        0);
    tbl[16] = mk(2'b11, 0, 32'h0,        0, 0,  1, 2'b10, 32'h0,        EDAT,         1);
    tbl[17] = mk(2'b11, 0, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[18] = mk(2'b11, 1, 32'h6666_6666, 0, 1,  0, 2'b01, 32'h6666_6666, 32'h0,        0);
    tbl[19] = mk(2'b11, 0, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[20] = mk(2'b11, 0, 32'h0,        0, 1,  1, 2'b00, 32'h0,        32'h0,        0);
    tbl[21] = mk(2'b11, 0, 32'h0,        0, 1,  1, 2'b00, 32'h0,        32'h0,        0);
    tbl[22] = mk(2'b11, 0, 32'h0,        0, 1,  1, 2'b00, 32'h0,        32'h0,        0);
    tbl[23] = mk(2'b11, 1, 32'h7777_7777, 0, 1,  1, 2'b10, 32'h0,        32'h7777_7777, 0);
    tbl[24] = mk(2'b01, 0, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[25] = mk(2'b00, 1, 32'h0,        0, 0,  0, 2'b00, 32'h0,        32'h0,        0);
    tbl[26] = mk(2'b11, 0, 32'h0,        0, 0, -1, 2'b00, 32'h0,        32'h0,        0);
    tbl[27] = mk(2'b11, 1, 32'h8888_8888, 0, 1,  0, 2'b01, 32'h8888_8888, 32'h0,        0);

    bus_rr.m_address = {A1, A0};
    bus_rr.m_wstrobe = {WS1, 4'h0};
    bus_rr.m_wdata   = {WD1, 32'h0};
    bus_fp.m_address = {A1, A0};
    bus_fp.m_wstrobe = {WS1, 4'h0};
    bus_fp.m_wdata   = {WD1, 32'h0};
    bus_fp.m_valid   = 2'b00;
    bus_fp.s_ready   = 1'b0;
    bus_fp.s_rdata   = 32'h0;
    bus_fp.s_irq     = 1'b0;

    // Reset state with requests present: outputs must stay quiet.
    reset_n = 1'b0;
    drive_rr(2'b11, 1'b1, 32'h0, 1'b1);
    #2;
    check("reset s_valid", 128'(bus_rr.s_valid), 128'(1'b0));
    check("reset m_ready", 128'(bus_rr.m_ready), 128'(2'b00));
    check("reset timeout", 128'(to_rr), 128'(1'b0));
    check("reset s_bus", 128'({bus_rr.s_address, bus_rr.s_wstrobe, bus_rr.s_wdata}), 128'(0));
    check("reset m_irq", 128'(bus_rr.m_irq), 128'(2'b11));
    drive_rr(2'b00, 1'b0, 32'h0, 1'b0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive_rr(tbl[i].mv, tbl[i].sr, tbl[i].rd, tbl[i].irq);
      @(negedge clk);
      check($sformatf("v%0d s_valid", i), 128'(bus_rr.s_valid), 128'(tbl[i].sv));
      check($sformatf("v%0d s_bus", i), 128'({bus_rr.s_address, bus_rr.s_wstrobe, bus_rr.s_wdata}),
            128'({tbl[i].sa, tbl[i].sw, tbl[i].swd}));
      check($sformatf("v%0d m_ready", i), 128'(bus_rr.m_ready), 128'(tbl[i].mr));
      check($sformatf("v%0d m_rdata", i), 128'(bus_rr.m_rdata), 128'({tbl[i].r1, tbl[i].r0}));
      check($sformatf("v%0d timeout", i), 128'(to_rr), 128'(tbl[i].to));
      check($sformatf("v%0d m_irq", i), 128'(bus_rr.m_irq), 128'({2{tbl[i].irq}}));
    end

    // Reset mid-BUSY: rr_ptr is 1 here, so the next grant would be channel 1 without reset.
    @(posedge clk); #1;
    drive_rr(2'b11, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive_rr(2'b11, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("pre-reset m_ready", 128'(bus_rr.m_ready), 128'(2'b10));
    check("pre-reset s_address", 128'(bus_rr.s_address), 128'(A1));
    #1 reset_n = 1'b0;
    #1;
    check("mid-reset s_valid", 128'(bus_rr.s_valid), 128'(1'b0));
    check("mid-reset m_ready", 128'(bus_rr.m_ready), 128'(2'b00));
    check("mid-reset s_address", 128'(bus_rr.s_address), 128'(0));
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset idle s_valid", 128'(bus_rr.s_valid), 128'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    check("post-reset grant addr", 128'(bus_rr.s_address), 128'(A0));
    check("post-reset m_ready", 128'(bus_rr.m_ready), 128'(2'b01));
    @(posedge clk); #1;
    drive_rr(2'b00, 1'b0, 32'h0, 1'b0);

    // Fixed priority: channel 0 wins every arbitration, channel 1 never completes.
    bus_fp.m_valid = 2'b11;
    bus_fp.s_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("fp%0d s_valid", k), 128'(bus_fp.s_valid), 128'(k % 2));
      check($sformatf("fp%0d m_ready", k), 128'(bus_fp.m_ready), 128'((k % 2 == 1) ? 2'b01 : 2'b00));
      check($sformatf("fp%0d s_address", k), 128'(bus_fp.s_address), 128'((k % 2 == 1) ? A0 : 32'h0));
      @(posedge clk); #1;
    end

    // Watchdog disabled: a stalled target keeps the transaction open indefinitely.
    bus_fp.m_valid = 2'b01;
    bus_fp.s_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("nowd%0d s_valid", k), 128'(bus_fp.s_valid), 128'(1'b1));
      check($sformatf("nowd%0d timeout", k), 128'(to_fp), 128'(1'b0));
      check($sformatf("nowd%0d m_ready", k), 128'(bus_fp.m_ready), 128'(2'b00));
    end
    @(posedge clk); #1;
    bus_fp.s_ready = 1'b1;
    @(negedge clk);
    check("nowd complete m_ready", 128'(bus_fp.m_ready), 128'(2'b01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

endmodule
